// File: rtl/uart_tx_if.sv
// Host-side byte interface of the UART transmitter.
// The host writes bytes into the FIFO and watches the full and overflow flags.
interface uart_tx_if;
   logic       i_wr;
   logic [7:0] i_data;
   logic       o_full;
   logic       o_ovf;

   modport master (
      output i_wr,
      output i_data,
      input  o_full,
      input  o_ovf
   );

   modport slave (
      input  i_wr,
      input  i_data,
      output o_full,
      output o_ovf
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: small byte FIFO feeding a start/8-data/parity/stop shifter.
// Bit timing is taken from an external one-cycle bit-rate strobe (i_clk_tx).
module uart_tx #(
   parameter int FIFO_AW = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   uart_tx_if.slave   host,
   input  logic       i_enable_n,
   input  logic       i_clk_tx,
   input  logic [1:0] i_parity,
   input  logic       i_int_clrtxn,
   output logic       o_tx_data,
   output logic       o_busy,
   output logic       o_tx_int
);

   localparam int DEPTH = 2 ** FIFO_AW;

   typedef logic [FIFO_AW:0] ptr_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   // FIFO state
   ptr_t wr_ptr_q, wr_ptr_d;
   ptr_t rd_ptr_q, rd_ptr_d;
   logic full_q, full_d;
   logic ovf_q, ovf_d;
   logic empty;
   logic wr_accept;
   logic pop;
   logic [7:0] head;
   logic [DEPTH-1:0][7:0] mem_rd;

   // Shifter state
   state_t     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] cnt_q, cnt_d;
   logic       tx_q, tx_d;
   logic       par_en_q, par_en_d;
   logic       par_bit_q, par_bit_d;
   logic       busy_q, busy_d;
   logic       int_q, int_d;
   logic       int_set;
   logic       can_start;

   // Full comes from the registered flag, so a write in a pop cycle while full is dropped.
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign wr_accept = host.i_wr && !full_q;
   assign head      = mem_rd[rd_ptr_q[FIFO_AW-1:0]];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_mem
         logic [7:0] entry_q;

         always_ff @(posedge i_clk) begin
            if (wr_accept && (wr_ptr_q[FIFO_AW-1:0] == FIFO_AW'(gi))) begin
               entry_q <= host.i_data;
            end
         end

         assign mem_rd[gi] = entry_q;
      end
   endgenerate

   always_comb begin
      wr_ptr_d = wr_accept ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
      full_d   = (wr_ptr_d[FIFO_AW] != rd_ptr_d[FIFO_AW]) &&
                 (wr_ptr_d[FIFO_AW-1:0] == rd_ptr_d[FIFO_AW-1:0]);
      ovf_d    = host.i_wr && full_q;
   end

   // Next-state and line logic; every transition is qualified by the bit strobe.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      tx_d      = tx_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      pop       = 1'b0;
      int_set   = 1'b0;
      can_start = !empty && !i_enable_n;

      if (i_clk_tx) begin
         case (state_q)
            ST_IDLE: begin
               if (can_start) begin
                  pop       = 1'b1;
                  shift_d   = head;
                  par_en_d  = !i_parity[1];
                  par_bit_d = i_parity[0] ? ~^head : ^head;
                  tx_d      = 1'b0;
                  state_d   = ST_START;
               end else begin
                  tx_d = 1'b1;
               end
            end

            ST_START: begin
               tx_d    = shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
               cnt_d   = 3'd0;
               state_d = ST_DATA;
            end

            ST_DATA: begin
               if (cnt_q != 3'd7) begin
                  cnt_d   = cnt_q + 3'd1;
                  tx_d    = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
               end else if (par_en_q) begin
                  tx_d    = par_bit_q;
                  state_d = ST_PARITY;
               end else begin
                  tx_d    = 1'b1;
                  state_d = ST_STOP;
               end
            end

            ST_PARITY: begin
               tx_d    = 1'b1;
               state_d = ST_STOP;
            end

            ST_STOP: begin
               // A queued byte follows immediately with its start bit, no idle gap.
               if (can_start) begin
                  pop       = 1'b1;
                  shift_d   = head;
                  par_en_d  = !i_parity[1];
                  par_bit_d = i_parity[0] ? ~^head : ^head;
                  tx_d      = 1'b0;
                  state_d   = ST_START;
               end else begin
                  tx_d    = 1'b1;
                  int_set = 1'b1;
                  state_d = ST_IDLE;
               end
            end

            default: begin
               tx_d    = 1'b1;
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);

      if (int_set) begin
         int_d = 1'b1;
      end else if (!i_int_clrtxn) begin
         int_d = 1'b0;
      end else begin
         int_d = int_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         full_q    <= 1'b0;
         ovf_q     <= 1'b0;
         state_q   <= ST_IDLE;
         shift_q   <= 8'h00;
         cnt_q     <= 3'd0;
         tx_q      <= 1'b1;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         busy_q    <= 1'b0;
         int_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         full_q    <= full_d;
         ovf_q     <= ovf_d;
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         tx_q      <= tx_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         busy_q    <= busy_d;
         int_q     <= int_d;
      end
   end

   assign o_tx_data   = tx_q;
   assign o_busy      = busy_q;
   assign o_tx_int    = int_q;
   assign host.o_full = full_q;
   assign host.o_ovf  = ovf_q;

endmodule
